// File: rtl/riscv8_pkg.sv
// Shared constants for the 8-bit RISC-V pipeline: widths, ALU control codes,
// ALU op classes and the funct3 values the decoder cares about.
package riscv8_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned REG_W  = 5;

    // ALU control codes; the ALU returns 0 for AluIllegal
    localparam logic [3:0] AluAnd     = 4'b0000;
    localparam logic [3:0] AluOr      = 4'b0001;
    localparam logic [3:0] AluAdd     = 4'b0010;
    localparam logic [3:0] AluSub     = 4'b0110;
    localparam logic [3:0] AluIllegal = 4'b1111;

    typedef enum logic [1:0] {
        AluOpMem    = 2'b00,
        AluOpBranch = 2'b01,
        AluOpRtype  = 2'b10,
        AluOpItype  = 2'b11
    } alu_op_e;

    localparam logic [2:0] F3AddSub = 3'b000;
    localparam logic [2:0] F3Or     = 3'b110;
    localparam logic [2:0] F3And    = 3'b111;

endpackage

// File: rtl/ex_forward_unit.sv
// Selects the freshest value of one source register: MEM beats WB beats the
// registered read data. x0 is never forwarded.
module ex_forward_unit #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned REG_W  = 5
) (
    input  logic [REG_W-1:0]  rs,
    input  logic [DATA_W-1:0] data,
    input  logic              mem_reg_write,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_write,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_result,
    output logic [DATA_W-1:0] fwd_data
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_reg_write && (mem_rd != '0) && (mem_rd == rs);
    assign wb_hit  = wb_reg_write && (wb_rd != '0) && (wb_rd == rs);

    // Priority mux: younger producer (MEM) wins
    always_comb begin
        if (mem_hit) begin
            fwd_data = mem_result;
        end else if (wb_hit) begin
            fwd_data = wb_result;
        end else begin
            fwd_data = data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, immediate select, ALU
// control decode and load-use hazard detection.
module id_ex_stage #(
    parameter int unsigned DATA_W = riscv8_pkg::DATA_W,
    parameter int unsigned REG_W  = riscv8_pkg::REG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [2:0]        id_funct3,
    input  logic              id_funct7b5,
    input  logic [1:0]        id_alu_op,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              id_branch,
    input  logic              mem_reg_write,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_write,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_result,
    output logic [DATA_W-1:0] alu_data1,
    output logic [DATA_W-1:0] alu_data2,
    output logic [3:0]        alu_control,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_branch,
    output logic [REG_W-1:0]  ex_rd,
    output logic              load_use_stall
);

    import riscv8_pkg::*;

    logic              valid_q;
    logic [REG_W-1:0]  rs1_q, rs2_q, rd_q;
    logic [DATA_W-1:0] rs1_data_q, rs2_data_q, imm_q;
    logic [2:0]        funct3_q;
    logic              funct7b5_q;
    alu_op_e           alu_op_q;
    logic              alu_src_q;
    logic              reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q, branch_q;

    logic [DATA_W-1:0] rs1_fwd, rs2_fwd;

    ex_forward_unit #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rs1 (
        .rs            (rs1_q),
        .data          (rs1_data_q),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_result     (wb_result),
        .fwd_data      (rs1_fwd)
    );

    ex_forward_unit #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rs2 (
        .rs            (rs2_q),
        .data          (rs2_data_q),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_result     (wb_result),
        .fwd_data      (rs2_fwd)
    );

    // Pipeline register: flush > stall > load. During a stall the operand
    // data re-captures its forwarded value so a producer that retires while
    // we wait is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            valid_q      <= 1'b0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            funct3_q     <= '0;
            funct7b5_q   <= 1'b0;
            alu_op_q     <= AluOpMem;
            alu_src_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            branch_q     <= 1'b0;
        end else if (stall) begin
            rs1_data_q <= rs1_fwd;
            rs2_data_q <= rs2_fwd;
        end else begin
            valid_q      <= id_valid;
            rs1_q        <= id_rs1;
            rs2_q        <= id_rs2;
            rd_q         <= id_rd;
            rs1_data_q   <= id_rs1_data;
            rs2_data_q   <= id_rs2_data;
            imm_q        <= id_imm;
            funct3_q     <= id_funct3;
            funct7b5_q   <= id_funct7b5;
            alu_op_q     <= alu_op_e'(id_alu_op);
            alu_src_q    <= id_alu_src;
            reg_write_q  <= id_reg_write;
            mem_read_q   <= id_mem_read;
            mem_write_q  <= id_mem_write;
            mem_to_reg_q <= id_mem_to_reg;
            branch_q     <= id_branch;
        end
    end

    // ALU control decode; bubbles always present as ILLEGAL
    always_comb begin
        alu_control = AluIllegal;
        if (valid_q) begin
            case (alu_op_q)
                AluOpMem:    alu_control = AluAdd;
                AluOpBranch: alu_control = AluSub;
                default: begin
                    case (funct3_q)
                        F3AddSub: alu_control = (alu_op_q == AluOpRtype && funct7b5_q) ?
                                                AluSub : AluAdd;
                        F3And:    alu_control = AluAnd;
                        F3Or:     alu_control = AluOr;
                        default:  alu_control = AluIllegal;
                    endcase
                end
            endcase
        end
    end

    assign alu_data1     = rs1_fwd;
    assign alu_data2     = alu_src_q ? imm_q : rs2_fwd;
    assign ex_store_data = rs2_fwd;

    assign ex_valid      = valid_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;
    assign ex_mem_to_reg = mem_to_reg_q;
    assign ex_branch     = branch_q;
    assign ex_rd         = rd_q;

    assign load_use_stall = valid_q && mem_read_q && (rd_q != '0) && id_valid &&
                            ((rd_q == id_rs1) || (rd_q == id_rs2));

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the stage.
module tb_id_ex_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       stall, flush, id_valid;
    logic [7:0] id_rs1_data, id_rs2_data, id_imm;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic [2:0] id_funct3;
    logic       id_funct7b5;
    logic [1:0] id_alu_op;
    logic       id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
    logic       mem_reg_write, wb_reg_write;
    logic [4:0] mem_rd, wb_rd;
    logic [7:0] mem_result, wb_result;
    logic [7:0] alu_data1, alu_data2, ex_store_data;
    logic [3:0] alu_control;
    logic       ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;
    logic [4:0] ex_rd;
    logic       load_use_stall;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .id_valid       (id_valid),
        .id_rs1_data    (id_rs1_data),
        .id_rs2_data    (id_rs2_data),
        .id_imm         (id_imm),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rd          (id_rd),
        .id_funct3      (id_funct3),
        .id_funct7b5    (id_funct7b5),
        .id_alu_op      (id_alu_op),
        .id_alu_src     (id_alu_src),
        .id_reg_write   (id_reg_write),
        .id_mem_read    (id_mem_read),
        .id_mem_write   (id_mem_write),
        .id_mem_to_reg  (id_mem_to_reg),
        .id_branch      (id_branch),
        .mem_reg_write  (mem_reg_write),
        .mem_rd         (mem_rd),
        .mem_result     (mem_result),
        .wb_reg_write   (wb_reg_write),
        .wb_rd          (wb_rd),
        .wb_result      (wb_result),
        .alu_data1      (alu_data1),
        .alu_data2      (alu_data2),
        .alu_control    (alu_control),
        .ex_store_data  (ex_store_data),
        .ex_valid       (ex_valid),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_mem_to_reg  (ex_mem_to_reg),
        .ex_branch      (ex_branch),
        .ex_rd          (ex_rd),
        .load_use_stall (load_use_stall)
    );

    // Model of the instruction currently held in EX
    typedef struct packed {
        logic       valid;
        logic [4:0] rs1, rs2, rd;
        logic [7:0] d1, d2, imm;
        logic [2:0] f3;
        logic       f7;
        logic [1:0] op;
        logic       src, rw, mr, mw, m2r, br;
    } st_t;

    st_t m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Freshest value of register r given its stale read data
    function automatic logic [7:0] freshest(input logic [4:0] r, input logic [7:0] stale);
        if (r == 5'd0) return stale;
        if (mem_reg_write && mem_rd == r) return mem_result;
        if (wb_reg_write && wb_rd == r) return wb_result;
        return stale;
    endfunction

    function automatic logic [3:0] model_ctrl(input st_t s);
        if (!s.valid) return 4'hF;
        if (s.op == 2'd0) return 4'h2;
        if (s.op == 2'd1) return 4'h6;
        if (s.f3 == 3'd0) return (s.op == 2'd2 && s.f7) ? 4'h6 : 4'h2;
        if (s.f3 == 3'd7) return 4'h0;
        if (s.f3 == 3'd6) return 4'h1;
        return 4'hF;
    endfunction

    task automatic check_outputs();
        logic [7:0] e1, e2;
        logic       lu;
        e1 = freshest(m.rs1, m.d1);
        e2 = freshest(m.rs2, m.d2);
        lu = m.valid && m.mr && m.rd != 0 && id_valid && (m.rd == id_rs1 || m.rd == id_rs2);
        check("alu_data1", 32'(alu_data1), 32'(e1));
        check("alu_data2", 32'(alu_data2), 32'(m.src ? m.imm : e2));
        check("store_data", 32'(ex_store_data), 32'(e2));
        check("alu_control", 32'(alu_control), 32'(model_ctrl(m)));
        check("ex_valid", 32'(ex_valid), 32'(m.valid));
        check("ex_rd", 32'(ex_rd), 32'(m.rd));
        check("ex_ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch}),
              32'({m.rw, m.mr, m.mw, m.m2r, m.br}));
        check("load_use", 32'(load_use_stall), 32'(lu));
    endtask

    // Called just after the rising edge with inputs still stable
    task automatic model_update();
        st_t n;
        if (!rst_n || flush) begin
            m = '0;
        end else if (stall) begin
            n = m;
            n.d1 = freshest(m.rs1, m.d1);
            n.d2 = freshest(m.rs2, m.d2);
            m = n;
        end else begin
            m = '{valid: id_valid, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                  d1: id_rs1_data, d2: id_rs2_data, imm: id_imm, f3: id_funct3,
                  f7: id_funct7b5, op: id_alu_op, src: id_alu_src, rw: id_reg_write,
                  mr: id_mem_read, mw: id_mem_write, m2r: id_mem_to_reg, br: id_branch};
        end
    endtask

    task automatic settle();
        #1;
        check_outputs();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; id_valid = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_funct3 = 0; id_funct7b5 = 0;
        id_alu_op = 0; id_alu_src = 0; id_reg_write = 0; id_mem_read = 0;
        id_mem_write = 0; id_mem_to_reg = 0; id_branch = 0;
        mem_reg_write = 0; mem_rd = 0; mem_result = 0;
        wb_reg_write = 0; wb_rd = 0; wb_result = 0;
    endtask

    task automatic random_inputs();
        stall = ($urandom_range(3) == 0);
        flush = ($urandom_range(9) == 0);
        id_valid = ($urandom_range(4) != 0);
        id_rs1_data = 8'($urandom); id_rs2_data = 8'($urandom); id_imm = 8'($urandom);
        id_rs1 = 5'($urandom_range(7)); id_rs2 = 5'($urandom_range(7));
        id_rd = 5'($urandom_range(7));
        id_funct3 = 3'($urandom); id_funct7b5 = 1'($urandom);
        id_alu_op = 2'($urandom); id_alu_src = 1'($urandom);
        id_reg_write = 1'($urandom); id_mem_read = 1'($urandom);
        id_mem_write = 1'($urandom); id_mem_to_reg = 1'($urandom); id_branch = 1'($urandom);
        mem_reg_write = 1'($urandom); mem_rd = 5'($urandom_range(7));
        mem_result = 8'($urandom);
        wb_reg_write = 1'($urandom); wb_rd = 5'($urandom_range(7));
        wb_result = 8'($urandom);
    endtask

    initial begin
        m = '0;
        idle_inputs();
        rst_n = 0;
        @(negedge clk);
        settle();
        check("reset_ctrl", 32'(alu_control), 32'hF);
        advance();
        rst_n = 1;
        advance();

        // R-type ADD
        id_valid = 1; id_alu_op = 2'b10; id_funct3 = 3'b000; id_funct7b5 = 0;
        id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd6; id_rs1_data = 8'h05; id_rs2_data = 8'h03;
        id_reg_write = 1;
        settle();
        advance();
        idle_inputs();
        settle();
        check("radd_ctrl", 32'(alu_control), 32'h2);
        check("radd_d1", 32'(alu_data1), 32'h05);
        check("radd_d2", 32'(alu_data2), 32'h03);
        check("radd_valid", 32'(ex_valid), 32'h1);

        // Double forward: MEM beats WB, then WB alone, then x0 never forwards
        id_valid = 1; id_alu_op = 2'b10; id_rs1 = 5'd3; id_rs1_data = 8'h11;
        advance();
        mem_reg_write = 1; mem_rd = 5'd3; mem_result = 8'hAA;
        wb_reg_write = 1; wb_rd = 5'd3; wb_result = 8'hBB;
        settle();
        check("fwd_mem", 32'(alu_data1), 32'hAA);
        mem_reg_write = 0;
        settle();
        check("fwd_wb", 32'(alu_data1), 32'hBB);
        id_rs1 = 5'd0;
        mem_reg_write = 1;
        advance();
        mem_rd = 5'd0; wb_rd = 5'd0;
        settle();
        check("fwd_x0", 32'(alu_data1), 32'h11);
        idle_inputs();

        // Load-use then flush
        id_valid = 1; id_mem_read = 1; id_rd = 5'd5; id_reg_write = 1; id_mem_to_reg = 1;
        advance();
        idle_inputs();
        id_valid = 1; id_rs2 = 5'd5; id_rs1 = 5'd1;
        settle();
        check("lu_flag", 32'(load_use_stall), 32'h1);
        flush = 1;
        advance();
        flush = 0;
        settle();
        check("flush_valid", 32'(ex_valid), 32'h0);
        check("flush_ctrl", 32'(alu_control), 32'hF);
        check("flush_rw", 32'(ex_reg_write), 32'h0);
        idle_inputs();

        // Stall refresh: WB producer present only on the first stall cycle
        id_valid = 1; id_alu_op = 2'b10; id_rs1 = 5'd4; id_rs1_data = 8'h00;
        advance();
        idle_inputs();
        stall = 1; wb_reg_write = 1; wb_rd = 5'd4; wb_result = 8'h7E;
        settle();
        advance();
        wb_reg_write = 0; wb_result = 8'h00;
        settle();
        advance();
        settle();
        advance();
        settle();
        check("stall_keep", 32'(alu_data1), 32'h7E);
        stall = 0;
        advance();

        // I-type OR with immediate, then illegal funct3
        id_valid = 1; id_alu_op = 2'b11; id_funct3 = 3'b110; id_alu_src = 1;
        id_imm = 8'hF0; id_rs1 = 5'd2; id_rs1_data = 8'h0F;
        advance();
        settle();
        check("itype_ctrl", 32'(alu_control), 32'h1);
        check("itype_d2", 32'(alu_data2), 32'hF0);
        id_funct3 = 3'b010;
        advance();
        settle();
        check("itype_illegal", 32'(alu_control), 32'hF);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            random_inputs();
            settle();
            advance();
        end

        // Asynchronous reset between edges
        random_inputs();
        stall = 1; flush = 0;
        settle();
        #2;
        rst_n = 0;
        #1;
        m = '0;
        check("areset_ctrl", 32'(alu_control), 32'hF);
        check("areset_ex", 32'({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
                                ex_mem_to_reg, ex_branch, ex_rd}), 32'h0);
        check_outputs();
        advance();
        rst_n = 1;
        for (int i = 0; i < 50; i++) begin
            random_inputs();
            settle();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
